// File: rtl/conv_unit_loader.sv
// Load-side sequencer for the conv-unit array: turns load commands plus a DDR word
// stream into parameter writes, buffer clears and broadcast feature/weight writes.
module conv_unit_loader #(
  parameter int N_CONV_UNIT = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int B_PARA      = 64,
  parameter int B_LEN       = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [N_CONV_UNIT-1:0] cmd_mask,
  input  logic [B_LEN-1:0]       cmd_len,
  input  logic                   cmd_clr,
  input  logic [B_PARA-1:0]      cmd_para,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   halt,
  input  logic [N_CONV_UNIT-1:0] fb_full,
  input  logic [N_CONV_UNIT-1:0] wb_full,
  output logic [B_PARA-1:0]      para,
  output logic [N_CONV_UNIT-1:0] para_we,
  output logic [N_CONV_UNIT-1:0] fb_clr,
  output logic [N_CONV_UNIT-1:0] wb_clr,
  output logic [N_CONV_UNIT-1:0] fb_we,
  output logic [N_CONV_UNIT-1:0] wb_we,
  output logic [DATA_WIDTH-1:0]  di,
  output logic                   busy,
  output logic                   done,
  output logic [B_LEN-1:0]       words_sent
);

  typedef enum logic [2:0] {S_IDLE, S_PARA, S_CLR, S_STREAM, S_DONE} state_t;
  localparam logic [1:0] OP_PARA = 2'd0;
  localparam logic [1:0] OP_FTM  = 2'd1;
  localparam logic [1:0] OP_WEI  = 2'd2;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [N_CONV_UNIT-1:0] mask_q, mask_d;
  logic [B_LEN-1:0]       len_q, len_d;
  logic [B_LEN-1:0]       words_q, words_d;
  logic [B_PARA-1:0]      para_q, para_d;
  logic [DATA_WIDTH-1:0]  di_q, di_d;
  logic [N_CONV_UNIT-1:0] para_we_q, para_we_d;
  logic [N_CONV_UNIT-1:0] fb_clr_q, fb_clr_d, wb_clr_q, wb_clr_d;
  logic [N_CONV_UNIT-1:0] fb_we_q, fb_we_d, wb_we_q, wb_we_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [N_CONV_UNIT-1:0] sel_full;
  logic                   tready;
  logic                   accept;
  logic [B_LEN-1:0]       words_inc;

  // Full is raised one word early by the units, so gating here covers the in-flight write.
  assign sel_full  = (op_q == OP_WEI) ? wb_full : fb_full;
  assign tready    = (state_q == S_STREAM) && !halt && !(|(sel_full & mask_q));
  assign accept    = s_tvalid && tready;
  assign words_inc = words_q + B_LEN'(1);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mask_d    = mask_q;
    len_d     = len_q;
    words_d   = words_q;
    para_d    = para_q;
    di_d      = di_q;
    para_we_d = '0;
    fb_clr_d  = '0;
    wb_clr_d  = '0;
    fb_we_d   = '0;
    wb_we_d   = '0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        mask_d  = cmd_mask;
        len_d   = cmd_len;
        words_d = '0;
        case (cmd_op)
          OP_PARA: begin
            state_d   = S_PARA;
            para_d    = cmd_para;
            para_we_d = cmd_mask;
          end
          OP_FTM, OP_WEI: begin
            if (cmd_clr) begin
              state_d = S_CLR;
              if (cmd_op == OP_FTM) fb_clr_d = cmd_mask;
              else                  wb_clr_d = cmd_mask;
            end else if (cmd_len != '0) begin
              state_d = S_STREAM;
            end else begin
              state_d = S_DONE;
            end
          end
          default: state_d = S_DONE;
        endcase
      end
      S_PARA: state_d = S_DONE;
      S_CLR:  state_d = (len_q != '0) ? S_STREAM : S_DONE;
      S_STREAM: if (accept) begin
        words_d = words_inc;
        di_d    = s_tdata;
        if (op_q == OP_FTM) fb_we_d = mask_q;
        else                wb_we_d = mask_q;
        if (words_inc == len_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort: accept is already blocked by the tready gate, so only clr/para strobes need killing.
    if (halt && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      para_we_d = '0;
      fb_clr_d  = '0;
      wb_clr_d  = '0;
      fb_we_d   = '0;
      wb_we_d   = '0;
    end
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      mask_q      <= '0;
      len_q       <= '0;
      words_q     <= '0;
      para_q      <= '0;
      di_q        <= '0;
      para_we_q   <= '0;
      fb_clr_q    <= '0;
      wb_clr_q    <= '0;
      fb_we_q     <= '0;
      wb_we_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      len_q       <= len_d;
      words_q     <= words_d;
      para_q      <= para_d;
      di_q        <= di_d;
      para_we_q   <= para_we_d;
      fb_clr_q    <= fb_clr_d;
      wb_clr_q    <= wb_clr_d;
      fb_we_q     <= fb_we_d;
      wb_we_q     <= wb_we_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign s_tready   = tready;
  assign para       = para_q;
  assign para_we    = para_we_q;
  assign fb_clr     = fb_clr_q;
  assign wb_clr     = wb_clr_q;
  assign fb_we      = fb_we_q;
  assign wb_we      = wb_we_q;
  assign di         = di_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_conv_unit_loader.sv
// Randomized bench for conv_unit_loader: a per-command behavioural model predicts
// strobes, data, ready and completion cycle by cycle from the command rules.
module tb_conv_unit_loader;
  localparam int N = 8, DW = 64, BP = 64, BL = 20;
  localparam logic [1:0] OP_PARA = 0, OP_FTM = 1, OP_WEI = 2, OP_NOP = 3;

  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_clr = 0, s_tvalid = 0, s_tready, halt = 0;
  logic busy, done;
  logic [1:0] cmd_op = 0;
  logic [N-1:0] cmd_mask = 0, fb_full = 0, wb_full = 0;
  logic [N-1:0] para_we, fb_clr, wb_clr, fb_we, wb_we;
  logic [BL-1:0] cmd_len = 0, words_sent;
  logic [BP-1:0] cmd_para = 0, para;
  logic [DW-1:0] s_tdata = 0, di;
  int nchk = 0, npass = 0;

  always #5 clk = ~clk;

  conv_unit_loader #(.N_CONV_UNIT(N), .DATA_WIDTH(DW), .B_PARA(BP), .B_LEN(BL)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mask(cmd_mask), .cmd_len(cmd_len), .cmd_clr(cmd_clr), .cmd_para(cmd_para),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .halt(halt),
    .fb_full(fb_full), .wb_full(wb_full), .para(para), .para_we(para_we),
    .fb_clr(fb_clr), .wb_clr(wb_clr), .fb_we(fb_we), .wb_we(wb_we), .di(di),
    .busy(busy), .done(done), .words_sent(words_sent));

  task automatic test_reset();
    #12;
    nchk++; if ({fb_we, wb_we, fb_clr, wb_clr, para_we} !== '0) $display("FAIL reset_strobes got=%h exp=0", {fb_we, wb_we, fb_clr, wb_clr, para_we}); else npass++;
    nchk++; if ({busy, done, s_tready, cmd_ready} !== 4'b0001) $display("FAIL reset_ctrl got=%b exp=0001", {busy, done, s_tready, cmd_ready}); else npass++;
    nchk++; if ({words_sent, di, para} !== '0) $display("FAIL reset_data got=%h exp=0", {words_sent, di, para}); else npass++;
    @(negedge clk); rst = 0;
    @(negedge clk);
    nchk++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); else npass++;
  endtask

  task automatic test_para(input logic [N-1:0] m, input logic [BP-1:0] p, input logic hlt);
    @(negedge clk);
    cmd_valid = 1; cmd_op = OP_PARA; cmd_mask = m; cmd_para = p; halt = hlt;
    nchk++; if (cmd_ready !== 1'b1) $display("FAIL para_cmd_ready got=%b exp=1", cmd_ready); else npass++;
    @(negedge clk); cmd_valid = 0; halt = 0;
    nchk++; if (para_we !== m || para !== p) $display("FAIL para_we got=%h/%h exp=%h/%h", para_we, para, m, p); else npass++;
    nchk++; if ({busy, done, cmd_ready} !== 3'b100) $display("FAIL para_ctrl got=%b exp=100", {busy, done, cmd_ready}); else npass++;
    @(negedge clk);
    nchk++; if (para_we !== '0 || done !== 1'b1 || para !== p) $display("FAIL para_done got=%h/%b/%h exp=0/1/%h", para_we, done, para, p); else npass++;
    @(negedge clk);
    nchk++; if ({busy, done, cmd_ready} !== 3'b001) $display("FAIL para_idle got=%b exp=001", {busy, done, cmd_ready}); else npass++;
  endtask

  task automatic test_nop();
    @(negedge clk);
    cmd_valid = 1; cmd_op = OP_NOP; cmd_mask = 8'hFF;
    @(negedge clk); cmd_valid = 0;
    nchk++; if (done !== 1'b1 || {para_we, fb_we, wb_we, fb_clr, wb_clr} !== '0) $display("FAIL nop_done got=%b/%h exp=1/0", done, {para_we, fb_we, wb_we, fb_clr, wb_clr}); else npass++;
    @(negedge clk);
    nchk++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL nop_idle got=%b/%b exp=1/0", cmd_ready, done); else npass++;
  endtask

  // Generic FTM/WEI load. Full window: sel_full = fw_val during stream cycles fw_lo..fw_hi.
  task automatic do_load(input logic [1:0] op, input logic [N-1:0] m, input logic [BL-1:0] len,
                         input logic clr, input int halt_at, input int valid_pct, input int full_pct,
                         input int fw_lo, input int fw_hi, input logic [N-1:0] fw_val);
    int ph, cnt, cyc, scyc;
    logic pend, exp_rdy, acc;
    logic [DW-1:0] pend_d;
    logic [N-1:0] sf, e_fw, e_ww, e_fc, e_wc;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_mask = m; cmd_len = len; cmd_clr = clr;
    nchk++; if (cmd_ready !== 1'b1) $display("FAIL load_cmd_ready got=%b exp=1", cmd_ready); else npass++;
    @(negedge clk); cmd_valid = 0;
    // ph: 0 clear cycle, 1 streaming, 2 done cycle, 3 back in idle
    ph = clr ? 0 : (len != 0 ? 1 : 2);
    cnt = 0; pend = 0; pend_d = '0; scyc = 0;
    for (cyc = 0; cyc < 3000 && ph != 3; cyc++) begin
      e_fw = (pend && op == OP_FTM) ? m : '0;
      e_ww = (pend && op == OP_WEI) ? m : '0;
      e_fc = (ph == 0 && op == OP_FTM) ? m : '0;
      e_wc = (ph == 0 && op == OP_WEI) ? m : '0;
      nchk++; if (fb_we !== e_fw || wb_we !== e_ww) $display("FAIL load_we cyc=%0d got=%h/%h exp=%h/%h", cyc, fb_we, wb_we, e_fw, e_ww); else npass++;
      if (pend) begin
        nchk++; if (di !== pend_d) $display("FAIL load_di cyc=%0d got=%h exp=%h", cyc, di, pend_d); else npass++;
      end
      nchk++; if (fb_clr !== e_fc || wb_clr !== e_wc) $display("FAIL load_clr cyc=%0d got=%h/%h exp=%h/%h", cyc, fb_clr, wb_clr, e_fc, e_wc); else npass++;
      nchk++; if (done !== (ph == 2) || busy !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL load_ctrl cyc=%0d got=%b%b%b exp=%b10", cyc, done, busy, cmd_ready, ph == 2); else npass++;
      nchk++; if (words_sent !== BL'(cnt)) $display("FAIL load_words cyc=%0d got=%0d exp=%0d", cyc, words_sent, cnt); else npass++;
      // drive the next cycle
      s_tvalid = ($urandom_range(99) < valid_pct);
      s_tdata = {$urandom, $urandom};
      fb_full = ($urandom_range(99) < full_pct) ? N'($urandom) : '0;
      wb_full = ($urandom_range(99) < full_pct) ? N'($urandom) : '0;
      if (ph == 1 && scyc >= fw_lo && scyc <= fw_hi) begin
        if (op == OP_FTM) fb_full = fw_val; else wb_full = fw_val;
      end
      halt = (ph == 1 && cnt == halt_at);
      if (halt) s_tvalid = 0;
      #1;
      sf = (op == OP_WEI) ? wb_full : fb_full;
      exp_rdy = (ph == 1) && !halt && ((sf & m) == '0);
      nchk++; if (s_tready !== exp_rdy) $display("FAIL load_tready cyc=%0d got=%b exp=%b", cyc, s_tready, exp_rdy); else npass++;
      acc = s_tvalid && exp_rdy;
      pend = acc; pend_d = s_tdata;
      if (halt) ph = 3;
      else case (ph)
        0: ph = (len != 0) ? 1 : 2;
        1: begin
          scyc++;
          if (acc) begin cnt++; if (cnt == int'(len)) ph = 2; end
        end
        default: ph = 3;
      endcase
      @(negedge clk);
      halt = 0;
    end
    nchk++; if (ph != 3) $display("FAIL load_timeout got=ph%0d exp=ph3", ph); else npass++;
    s_tvalid = 0; fb_full = 0; wb_full = 0;
    repeat (2) begin
      nchk++; if ({fb_we, wb_we, done, busy, cmd_ready} !== {{(2*N){1'b0}}, 3'b001}) $display("FAIL load_idle got=%h/%h/%b%b%b exp=0/0/001", fb_we, wb_we, done, busy, cmd_ready); else npass++;
      nchk++; if (words_sent !== BL'(cnt)) $display("FAIL load_final_words got=%0d exp=%0d", words_sent, cnt); else npass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1; cmd_op = OP_FTM; cmd_mask = 8'hFF; cmd_len = 10; cmd_clr = 0;
    @(negedge clk); cmd_valid = 0; s_tvalid = 1; s_tdata = 64'h1234;
    repeat (2) @(negedge clk);
    nchk++; if (fb_we !== 8'hFF) $display("FAIL rstmid_pre got=%h exp=ff", fb_we); else npass++;
    @(posedge clk); #2 rst = 1; #1;
    nchk++; if ({fb_we, wb_we, fb_clr, wb_clr, para_we} !== '0 || {busy, done, s_tready, cmd_ready} !== 4'b0001) $display("FAIL rstmid_outs got=%h/%b exp=0/0001", {fb_we, wb_we, fb_clr, wb_clr, para_we}, {busy, done, s_tready, cmd_ready}); else npass++;
    @(negedge clk); rst = 0; s_tvalid = 0;
    @(negedge clk);
    nchk++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || words_sent !== '0 || fb_we !== '0) $display("FAIL rstmid_after got=%b%b/%0d/%h exp=10/0/0", cmd_ready, busy, words_sent, fb_we); else npass++;
  endtask

  initial begin
    test_reset();
    test_para(8'h05, 64'hDEAD, 1'b0);
    test_nop();
    do_load(OP_FTM, 8'hFF, 4, 1, -1, 100, 0, 0, -1, 0);        // clear then 4 words
    do_load(OP_WEI, 8'h08, 6, 0, -1, 100, 0, 2, 4, 8'h08);     // back-pressure window
    do_load(OP_FTM, 8'hFF, 0, 0, -1, 100, 0, 0, -1, 0);        // zero length
    do_load(OP_WEI, 8'h3C, 0, 1, -1, 100, 0, 0, -1, 0);        // clear only
    do_load(OP_FTM, 8'hA5, 10, 0, 3, 100, 0, 0, -1, 0);        // halt after 3
    do_load(OP_WEI, 8'h00, 7, 0, -1, 80, 60, 0, -1, 0);        // empty mask ignores full
    test_para(8'h3C, 64'h0123_4567_89AB_CDEF, 1'b1);           // halt in idle ignored
    test_reset_mid();
    do_load(OP_FTM, 8'h81, 5, 1, -1, 100, 0, 0, -1, 0);
    for (int i = 0; i < 12; i++) begin
      do_load($urandom_range(1) ? OP_WEI : OP_FTM, ($urandom_range(4) == 0) ? 8'h00 : N'($urandom),
              BL'($urandom_range(12)), 1'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(8)) : -1,
              70, 30, 0, -1, 0);
      if (i % 4 == 0) test_para(N'($urandom), {$urandom, $urandom}, 1'b0);
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
